jt12_timer_bank: RTL

JT12_TIMER_BANK -- requirements
Module: jt12_timer_bank

---
 rtl/jt12_timer_bank.sv | 96 +++++++++
 1 files changed

// File: rtl/jt12_timer_bank.sv
// rtl/jt12_timer_bank.sv - bank of independent prescaled reload timers with overflow flags and IRQ
//
// Ports:
//   clk, rst_n     single clock, asynchronous active-low reset
//   cen            count-enable tick; prescalers only advance while high
//   load_val       per-timer reload value, timer i at [i*W +: W]
//   presc          per-timer prescale, timer i counts once every presc_i+1 cen ticks
//   set_run        per-timer start/restart pulse (reloads counter, clears prescaler)
//   clr_run        per-timer stop pulse (wins over set_run, freezes counter)
//   irq_en         per-timer enable for latching the overflow flag
//   clr_flag       per-timer flag clear pulse (a same-cycle flag-setting overflow wins)
//   flag           registered overflow flags
//   overflow       registered one-cycle overflow pulse, not gated by irq_en
//   irq_n          active-low interrupt, low while any flag is set

module jt12_timer_bank #(
    parameter int NTIM = 2,
    parameter int W    = 10,
    parameter int PSW  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic [NTIM*W-1:0] load_val,
    input  logic [NTIM*PSW-1:0] presc,
    input  logic [NTIM-1:0]   set_run,
    input  logic [NTIM-1:0]   clr_run,
    input  logic [NTIM-1:0]   irq_en,
    input  logic [NTIM-1:0]   clr_flag,
    output logic [NTIM-1:0]   flag,
    output logic [NTIM-1:0]   overflow,
    output logic              irq_n
);

    logic [NTIM-1:0]          run_q, run_d;
    logic [NTIM-1:0][W-1:0]   cnt_q, cnt_d;
    logic [NTIM-1:0][PSW-1:0] psc_q, psc_d;
    logic [NTIM-1:0]          flag_q, flag_d;
    logic [NTIM-1:0]          ovf_q, ovf_d;
    logic [NTIM-1:0]          tick;

    always_comb begin
        run_d  = run_q;
        cnt_d  = cnt_q;
        psc_d  = psc_q;
        ovf_d  = '0;
        flag_d = flag_q;
        tick   = '0;
        for (int i = 0; i < NTIM; i++) begin
            // >= rather than == so that lowering presc below the current
            // prescaler count ticks immediately instead of wrapping around.
            tick[i] = run_q[i] & cen & (psc_q[i] >= presc[i*PSW +: PSW]);
            if (clr_run[i]) begin
                run_d[i] = 1'b0;
            end else if (set_run[i]) begin
                run_d[i] = 1'b1;
                cnt_d[i] = load_val[i*W +: W];
                psc_d[i] = '0;
            end else if (run_q[i] && cen) begin
                if (tick[i]) begin
                    psc_d[i] = '0;
                    if (cnt_q[i] == {W{1'b1}}) begin
                        cnt_d[i] = load_val[i*W +: W];
                        ovf_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end else begin
                    psc_d[i] = psc_q[i] + 1'b1;
                end
            end
            flag_d[i] = (ovf_d[i] & irq_en[i]) | (flag_q[i] & ~clr_flag[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q  <= '0;
            cnt_q  <= '0;
            psc_q  <= '0;
            flag_q <= '0;
            ovf_q  <= '0;
        end else begin
            run_q  <= run_d;
            cnt_q  <= cnt_d;
            psc_q  <= psc_d;
            flag_q <= flag_d;
            ovf_q  <= ovf_d;
        end
    end

    assign flag     = flag_q;
    assign overflow = ovf_q;
    assign irq_n    = ~(|flag_q);

endmodule
